// File: rtl/stroke_pkg.sv
// stroke_pkg: shared types and constants for the stroke extent finder
package stroke_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACCUM, REPORT} state_t;
  typedef logic [10:0] x_t;
  typedef logic [9:0] y_t;
  localparam x_t X_INIT = 11'd2047;
  localparam y_t Y_INIT = 10'd1023;
endpackage

// File: rtl/stroke_extent_finder_if.sv
// stroke_extent_finder_if: pixel stream in, frame report out
interface stroke_extent_finder_if import stroke_pkg::*; #(
  parameter int COUNT_W = 20
);
  x_t hcount_in;
  y_t vcount_in;
  logic valid_in;
  logic mask_in;
  logic new_frame_in;
  logic capture_req_in;
  logic busy_out;
  logic done_out;
  logic hit_out;
  x_t x_out_1;
  y_t y_out_1;
  x_t x_out_2;
  y_t y_out_2;
  logic [COUNT_W-1:0] pixel_count_out;
  modport master (
    output hcount_in, vcount_in, valid_in, mask_in, new_frame_in, capture_req_in,
    input busy_out, done_out, hit_out, x_out_1, y_out_1, x_out_2, y_out_2, pixel_count_out
  );
  modport slave (
    input hcount_in, vcount_in, valid_in, mask_in, new_frame_in, capture_req_in,
    output busy_out, done_out, hit_out, x_out_1, y_out_1, x_out_2, y_out_2, pixel_count_out
  );
endinterface

// File: rtl/extent_axis_tracker.sv
// extent_axis_tracker: running min/max of one coordinate axis
module extent_axis_tracker #(
  parameter int W = 11,
  parameter logic [W-1:0] MIN_INIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic en,
  input  logic [W-1:0] coord,
  output logic [W-1:0] min_v,
  output logic [W-1:0] max_v
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || init) begin
      min_v <= MIN_INIT;
      max_v <= '0;
    end else if (en) begin
      if (coord < min_v) min_v <= coord;
      if (coord > max_v) max_v <= coord;
    end
  end
endmodule

// File: rtl/stroke_extent_finder.sv
// stroke_extent_finder: per-frame bounding box of stroke-masked pixels
module stroke_extent_finder import stroke_pkg::*; #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int MIN_PIXELS = 64,
  parameter int COUNT_W = 20
) (
  input logic clk_in,
  input logic rst_n_in,
  stroke_extent_finder_if.slave bus
);
  state_t state;
  logic accept, init, hit_now;
  logic [COUNT_W-1:0] count;
  x_t min_x, max_x;
  y_t min_y, max_y;
  always_comb begin
    accept = bus.valid_in && bus.mask_in && 32'(bus.hcount_in) < H_ACTIVE &&
             32'(bus.vcount_in) < V_ACTIVE && state == ACCUM && !bus.new_frame_in;
    init = state == REPORT || (state == WAIT_SOF && bus.capture_req_in && bus.new_frame_in);
    hit_now = count >= COUNT_W'(MIN_PIXELS);
  end
  extent_axis_tracker #(.W($bits(x_t)), .MIN_INIT(X_INIT)) x_trk (
    .clk(clk_in), .rst_n(rst_n_in), .init(init), .en(accept),
    .coord(bus.hcount_in), .min_v(min_x), .max_v(max_x)
  );
  extent_axis_tracker #(.W($bits(y_t)), .MIN_INIT(Y_INIT)) y_trk (
    .clk(clk_in), .rst_n(rst_n_in), .init(init), .en(accept),
    .coord(bus.vcount_in), .min_v(min_y), .max_v(max_y)
  );
  // Results latch as the frame closes so they are valid alongside done_out in REPORT
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      count <= '0;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.hit_out <= 1'b0;
      bus.x_out_1 <= '0;
      bus.y_out_1 <= '0;
      bus.x_out_2 <= '0;
      bus.y_out_2 <= '0;
      bus.pixel_count_out <= '0;
    end else begin
      bus.done_out <= 1'b0;
      if (init) count <= '0;
      else if (accept && !(&count)) count <= count + 1'b1;
      case (state)
        IDLE: if (bus.capture_req_in) begin
          state <= WAIT_SOF;
          bus.busy_out <= 1'b1;
        end
        WAIT_SOF: if (!bus.capture_req_in) begin
          state <= IDLE;
          bus.busy_out <= 1'b0;
        end else if (bus.new_frame_in) state <= ACCUM;
        ACCUM: if (bus.new_frame_in) begin
          state <= REPORT;
          bus.busy_out <= 1'b0;
          bus.done_out <= 1'b1;
          bus.hit_out <= hit_now;
          bus.pixel_count_out <= count;
          if (hit_now) begin
            bus.x_out_1 <= min_x;
            bus.y_out_1 <= min_y;
            bus.x_out_2 <= max_x;
            bus.y_out_2 <= max_y;
          end
        end
        REPORT: begin
          state <= bus.capture_req_in ? ACCUM : IDLE;
          bus.busy_out <= bus.capture_req_in;
        end
      endcase
    end
  end
endmodule
